// File: rtl/pwm_multichannel_ctrl_if.sv
// Button/PWM bundle for pwm_multichannel_ctrl: the bench side drives the raw buttons
// (master), the controller drives the PWM and display outputs (slave).
interface pwm_multichannel_ctrl_if #(
    parameter int CHANNELS = 4,
    parameter int DUTY_W   = 8
);
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                btn_inc;
    logic                btn_dec;
    logic                btn_sel;
    logic [CHANNELS-1:0] pwm_out;
    logic [SEL_W-1:0]    sel_ch;
    logic [DUTY_W-1:0]   sel_duty;
    logic                period_start;
    logic [5:0]          dbg_state;    // debouncer states {sel, dec, inc}, 2 bits each

    modport master (
        output btn_inc, btn_dec, btn_sel,
        input  pwm_out, sel_ch, sel_duty, period_start, dbg_state
    );
    modport slave (
        input  btn_inc, btn_dec, btn_sel,
        output pwm_out, sel_ch, sel_duty, period_start, dbg_state
    );
endinterface

// File: rtl/pwm_multichannel_ctrl.sv
// Multi-channel PWM with debounced inc/dec/select buttons and a shared timebase.
// Define PWM_PHASE_STAGGER_EN to spread channel phases evenly across the period.
module pwm_multichannel_ctrl #(
    parameter int CHANNELS        = 4,
    parameter int DUTY_W          = 8,
    parameter int CLK_DIV         = 5000,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int STEP            = 16
) (
    input logic                    clk,
    input logic                    rst,
    pwm_multichannel_ctrl_if.slave bus
);
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int NB    = 3;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DUTY_W:0]   DUTY_MAX = {1'b0, {DUTY_W{1'b1}}};
    localparam logic [DUTY_W:0]   STEP_WD  = (DUTY_W + 1)'(STEP);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(CHANNELS - 1);

    typedef enum logic [1:0] {RELEASED, PRESS_PEND, PRESSED, REL_PEND} deb_state_t;

    logic [NB-1:0]    raw, sync1, sync2, press;
    deb_state_t       state_q [NB];
    deb_state_t       state_d [NB];
    logic [CNT_W-1:0] cnt_q [NB];
    logic [CNT_W-1:0] cnt_d [NB];

    assign raw = {bus.btn_sel, bus.btn_dec, bus.btn_inc};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (rst) begin
                state_q[b] <= RELEASED;
                cnt_q[b]   <= '0;
            end else begin
                state_q[b] <= state_d[b];
                cnt_q[b]   <= cnt_d[b];
            end
        end
    end

    // cnt holds the number of consecutive samples already seen at the new level
    always_comb begin
        press = '0;
        for (int b = 0; b < NB; b++) begin
            state_d[b] = state_q[b];
            cnt_d[b]   = cnt_q[b];
            case (state_q[b])
                RELEASED: if (sync2[b]) begin
                    state_d[b] = PRESS_PEND;
                    cnt_d[b]   = CNT_W'(1);
                end
                PRESS_PEND: if (!sync2[b]) begin
                    state_d[b] = RELEASED;
                    cnt_d[b]   = '0;
                end else if (cnt_q[b] >= CNT_LAST) begin
                    state_d[b] = PRESSED;
                    cnt_d[b]   = '0;
                    press[b]   = 1'b1;
                end else begin
                    cnt_d[b] = cnt_q[b] + 1'b1;
                end
                PRESSED: if (!sync2[b]) begin
                    state_d[b] = REL_PEND;
                    cnt_d[b]   = CNT_W'(1);
                end
                REL_PEND: if (sync2[b]) begin
                    state_d[b] = PRESSED;
                    cnt_d[b]   = '0;
                end else if (cnt_q[b] >= CNT_LAST) begin
                    state_d[b] = RELEASED;
                    cnt_d[b]   = '0;
                end else begin
                    cnt_d[b] = cnt_q[b] + 1'b1;
                end
                default: begin
                    state_d[b] = RELEASED;
                    cnt_d[b]   = '0;
                end
            endcase
        end
    end

    logic [DIV_W-1:0]  presc_q;
    logic [DUTY_W-1:0] phase_q;
    logic              tick, wrap;

    assign tick = (presc_q == DIV_LAST);
    assign wrap = tick && (phase_q == {DUTY_W{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            phase_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
            phase_q <= phase_q + 1'b1;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    logic [DUTY_W-1:0] shadow_q [CHANNELS];
    logic [DUTY_W-1:0] active_q [CHANNELS];
    logic [SEL_W-1:0]  sel_q;
    logic [DUTY_W:0]   cur_wide, inc_sum;
    logic [DUTY_W-1:0] inc_val, dec_val;
    logic              inc_ok, dec_ok;

    assign inc_ok   = press[0] && !press[1];
    assign dec_ok   = press[1] && !press[0];
    assign cur_wide = {1'b0, shadow_q[sel_q]};
    assign inc_sum  = cur_wide + STEP_WD;
    assign inc_val  = (inc_sum > DUTY_MAX) ? DUTY_MAX[DUTY_W-1:0] : inc_sum[DUTY_W-1:0];
    assign dec_val  = (cur_wide < STEP_WD) ? '0 : cur_wide[DUTY_W-1:0] - STEP_WD[DUTY_W-1:0];

    // Non-blocking copy on wrap picks up the shadow as it was before any same-cycle press
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < CHANNELS; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
            sel_q <= '0;
        end else begin
            if (wrap) begin
                for (int k = 0; k < CHANNELS; k++) active_q[k] <= shadow_q[k];
            end
            if (inc_ok)      shadow_q[sel_q] <= inc_val;
            else if (dec_ok) shadow_q[sel_q] <= dec_val;
            if (press[2])    sel_q <= (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
        end
    end

    logic [CHANNELS-1:0] pwm_d, pwm_q;

`ifdef PWM_PHASE_STAGGER_EN
    localparam int PH_STEP = (1 << DUTY_W) / CHANNELS;
`endif

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [DUTY_W-1:0] cmp_phase;
`ifdef PWM_PHASE_STAGGER_EN
        assign cmp_phase = phase_q + DUTY_W'(k * PH_STEP);
`else
        assign cmp_phase = phase_q;
`endif
        assign pwm_d[k] = (cmp_phase < active_q[k]);
    end

    always_ff @(posedge clk) begin
        if (rst) pwm_q <= '0;
        else     pwm_q <= pwm_d;
    end

    assign bus.pwm_out      = pwm_q;
    assign bus.sel_ch       = sel_q;
    assign bus.sel_duty     = shadow_q[sel_q];
    assign bus.period_start = wrap;
    assign bus.dbg_state    = {state_q[2], state_q[1], state_q[0]};
endmodule

// File: tb/tb_pwm_multichannel_ctrl.sv
// Self-checking bench for pwm_multichannel_ctrl: directed button sequences plus random
// button activity, compared every cycle against a cycle-count based behavioural model.
module tb_pwm_multichannel_ctrl;
  localparam int CHANNELS        = 4;
  localparam int DUTY_W          = 4;
  localparam int CLK_DIV         = 2;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int STEP            = 4;
  localparam int SEL_W           = 2;
  localparam int NPH             = 1 << DUTY_W;
  localparam int PERIOD_CLK      = CLK_DIV * NPH;
  localparam int DMAX            = NPH - 1;
  localparam int VW              = CHANNELS + SEL_W + DUTY_W + 1;
`ifdef PWM_PHASE_STAGGER_EN
  localparam int STAG = NPH / CHANNELS;
`else
  localparam int STAG = 0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pwm_multichannel_ctrl_if #(.CHANNELS(CHANNELS), .DUTY_W(DUTY_W)) bus ();

  pwm_multichannel_ctrl #(
    .CHANNELS(CHANNELS), .DUTY_W(DUTY_W), .CLK_DIV(CLK_DIV),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .STEP(STEP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // behavioural model: time since reset, per-button accepted level and run length
  int n;
  int shadow [CHANNELS];
  int active [CHANNELS];
  int msel;
  int ph;
  bit lvl [3];
  int run [3];
  bit s1 [3];
  bit s2 [3];
  bit raw [3];
  bit prs [3];
  logic [CHANNELS-1:0] npwm = '0;
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] exp_v, act_v;

  always @(posedge clk) begin
    raw = '{bus.btn_inc, bus.btn_dec, bus.btn_sel};
    if (rst) begin
      n = 0;
      msel = 0;
      npwm = '0;
      for (int k = 0; k < CHANNELS; k++) begin
        shadow[k] = 0;
        active[k] = 0;
      end
      for (int b = 0; b < 3; b++) begin
        lvl[b] = 0; run[b] = 0; s1[b] = 0; s2[b] = 0;
      end
    end else begin
      ph = (n / CLK_DIV) % NPH;
      for (int k = 0; k < CHANNELS; k++)
        npwm[k] = (((ph + k * STAG) % NPH) < active[k]);
      if (n % PERIOD_CLK == PERIOD_CLK - 1) begin
        for (int k = 0; k < CHANNELS; k++) active[k] = shadow[k];
      end
      for (int b = 0; b < 3; b++) begin
        prs[b] = 0;
        if (s2[b] != lvl[b]) begin
          run[b]++;
          if (run[b] == DEBOUNCE_CYCLES) begin
            lvl[b] = s2[b];
            run[b] = 0;
            prs[b] = lvl[b];
          end
        end else begin
          run[b] = 0;
        end
      end
      for (int b = 0; b < 3; b++) begin
        s2[b] = s1[b];
        s1[b] = raw[b];
      end
      if (prs[0] && !prs[1])
        shadow[msel] = (shadow[msel] + STEP > DMAX) ? DMAX : shadow[msel] + STEP;
      else if (prs[1] && !prs[0])
        shadow[msel] = (shadow[msel] < STEP) ? 0 : shadow[msel] - STEP;
      if (prs[2]) msel = (msel + 1) % CHANNELS;
      n++;
    end
    exp_q.push_back({npwm, SEL_W'(msel), DUTY_W'(shadow[msel]),
                     ((n % PERIOD_CLK) == PERIOD_CLK - 1)});
  end

  // scoreboard: compare every cycle on the falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {bus.pwm_out, bus.sel_ch, bus.sel_duty, bus.period_start};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        if (errors <= 20)
          $display("FAIL model_cmp t=%0t actual={pwm,sel,duty,ps}=%b required=%b",
                   $time, act_v, exp_v);
      end
    end
  end

  // driver tasks
  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0:       bus.btn_inc = v;
      1:       bus.btn_dec = v;
      default: bus.btn_sel = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    cycles(10);
    set_btn(b, 1'b0);
    cycles(10);
  endtask

  task automatic do_reset(input int k);
    rst = 1'b1;
    cycles(k);
    rst = 1'b0;
  endtask

  task automatic wait_ps();
    bit ok;
    ok = 0;
    for (int i = 0; i < 3 * PERIOD_CLK && !ok; i++) begin
      @(negedge clk);
      if (bus.period_start) ok = 1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL period_start_timeout actual=none required=pulse within %0d clk",
               3 * PERIOD_CLK);
    end
  endtask

  task automatic count_high(input int ch, input int len, output int cnt);
    cnt = 0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      cnt += int'(bus.pwm_out[ch]);
    end
  endtask

  task automatic bounce(input int b);
    for (int i = 0; i < 10; i++) begin
      set_btn(b, (i % 2) == 0);
      cycles(2);
    end
    set_btn(b, 1'b0);
    cycles(10);
  endtask

  int c1, c2;
  int i0, i1;

  initial begin
    rst = 1'b1;
    bus.btn_inc = 1'b0;
    bus.btn_dec = 1'b0;
    bus.btn_sel = 1'b0;
    cycles(3);
    rst = 1'b0;

    // mid-run reset discards the earlier press and any in-flight one
    press(0);
    bus.btn_inc = 1'b1;
    cycles(4);
    do_reset(3);
    bus.btn_inc = 1'b0;
    check("rst_pwm", int'(bus.pwm_out), 0);
    check("rst_sel_ch", int'(bus.sel_ch), 0);
    check("rst_sel_duty", int'(bus.sel_duty), 0);
    check("rst_period_start", int'(bus.period_start), 0);
    cycles(12);

    // increment, pwm high time, saturation, one decrement
    repeat (3) press(0);
    check("inc3_duty", int'(bus.sel_duty), 12);
    wait_ps();
    cycles(1);
    count_high(0, PERIOD_CLK, c1);
    check("duty12_high_clk", c1, 24);
    repeat (2) press(0);
    check("inc_saturate", int'(bus.sel_duty), 15);
    press(1);
    check("dec_step", int'(bus.sel_duty), 11);
    press(0);

    // bounce rejection
    bounce(0);
    check("bounce_inc", int'(bus.sel_duty), 15);
    bounce(1);
    check("bounce_dec", int'(bus.sel_duty), 15);

    // channel select
    press(2);
    check("sel1_ch", int'(bus.sel_ch), 1);
    check("sel1_duty", int'(bus.sel_duty), 0);
    repeat (3) press(2);
    check("sel_wrap_ch", int'(bus.sel_ch), 0);
    check("sel_wrap_duty", int'(bus.sel_duty), 15);

    // mid-period duty change takes effect only at the next period
    do_reset(3);
    repeat (2) press(0);
    check("mid_start_duty", int'(bus.sel_duty), 8);
    wait_ps();
    cycles(1);
    fork
      begin
        count_high(0, PERIOD_CLK, c1);
        count_high(0, PERIOD_CLK, c2);
      end
      begin
        cycles(6);
        press(0);
      end
    join
    check("mid_cur_period", c1, 16);
    check("mid_next_period", c2, 24);
    check("mid_end_duty", int'(bus.sel_duty), 12);

    // corner presses
    bus.btn_inc = 1'b1;
    bus.btn_dec = 1'b1;
    cycles(10);
    bus.btn_inc = 1'b0;
    bus.btn_dec = 1'b0;
    cycles(10);
    check("inc_dec_same", int'(bus.sel_duty), 12);
    press(2);
    press(1);
    check("dec_floor_ch", int'(bus.sel_ch), 1);
    check("dec_floor_duty", int'(bus.sel_duty), 0);

`ifdef PWM_PHASE_STAGGER_EN
    press(0);
    press(2); press(0);
    press(2); press(0);
    press(2); press(1); press(1);
    check("stagger_ch0_duty", int'(bus.sel_duty), 4);
    wait_ps();
    cycles(1);
    wait_ps();
    cycles(1);
    i0 = -1;
    i1 = -1;
    for (int i = 0; i < PERIOD_CLK; i++) begin
      @(negedge clk);
      if (i0 < 0 && bus.pwm_out[0]) i0 = i;
      if (i1 < 0 && bus.pwm_out[1]) i1 = i;
    end
    check("stagger_ch0_rise", i0, 0);
    check("stagger_ch1_rise", i1, 24);
`endif

    // random button activity
    do_reset(2);
    for (int it = 0; it < 45; it++) begin
      int m;
      m = $urandom_range(0, 7);
      bus.btn_inc = m[0];
      bus.btn_dec = m[1];
      bus.btn_sel = m[2];
      cycles($urandom_range(1, 14));
      bus.btn_inc = 1'b0;
      bus.btn_dec = 1'b0;
      bus.btn_sel = 1'b0;
      cycles($urandom_range(1, 14));
      if ($urandom_range(0, 19) == 0) do_reset(1);
    end

    cycles(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
